seq_detect_moore_overlap: RTL and testbench
===========================================

# seq_detect_moore_overlap

Moore-type serial pattern detector with overlap. It samples a 1-bit input stream on every rising clock edge and asserts `out` for exactly one cycle whenever the most recent PATTERN_LEN input bits equal PATTERN; the default pattern is 1101. It sits on a serial data path, such as a frame-sync or marker detector, and drives a registered match flag to downstream control logic.

## Interface
- PATTERN_LEN, default 4: pattern length in bits; legal range 2..16.
- PATTERN, default 4'b1101: target sequence; the MSB is the first bit received.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  one clock; reset is synchronous and active-high.
- in  input  1  serial data bit, sampled on each rising `clk` edge.
- out  output  1  match flag; a Moore output decoded from state only.
- match_count  output  8  number of matches detected; present only with SEQ_DET_COUNT_EN.

## Operation
- State S_k, for k = 0..PATTERN_LEN, means the longest prefix of PATTERN that is a suffix of the received stream has length k.
- Encoding: binary, width ceil(log2(PATTERN_LEN+1)).
- Next state from S_k with input b: the length of the longest prefix of PATTERN that is a suffix of (PATTERN[prefix k] followed by b). This is the KMP failure rule, so overlap is fully supported.
- The next-state function is computed combinationally from the parameters using a function or generate loop. Hand-coding a table is not allowed.
- out = 1 if and only if state == S_PATTERN_LEN. `in` has no combinational path to `out`.
- Default 1101 transitions:
  - S0: 1→S1, 0→S0
  - S1: 1→S2, 0→S0
  - S2: 1→S2, 0→S3
  - S3: 1→S4, 0→S0
  - S4 (out=1): 1→S2, 0→S0
- Reset: state = S0 and out = 0. Reset has priority over `in`.
- Reset asserted mid-sequence discards all partial-match history.
- X on `in` is outside the operating range; no recovery behaviour is specified.

## Timing
- Latency: `out` rises on the same rising edge that samples the final pattern bit, and is therefore visible during the following cycle.
- `out` is high for exactly one cycle per match, unless the next sampled bits immediately complete another overlapping match.
- Back-to-back matches can occur at most every (PATTERN_LEN − p) cycles, where p is the longest proper border of PATTERN. For 1101, p = 1, so the minimum spacing is 3 cycles.
- While `reset` is high, `out` is 0 starting from the first rising edge at which reset is sampled.
- Detection restarts from S0 on the first edge after reset deasserts.

## Configuration
- SEQ_DET_COUNT_EN defined:
  - The `match_count` port exists.
  - It increments by 1 on every edge where the next state is S_PATTERN_LEN, and saturates at 255.
  - `reset` clears it to 0.
- SEQ_DET_COUNT_EN undefined:
  - The port and its counter logic are absent.
  - Detection behaviour is identical in both builds.

## Test plan
- Reset then single match:
  - Assert `reset` for 1 edge, then drive `in` = 0,1,1,0,1 on consecutive edges.
  - Required: `out` = 0 during reset and the first 4 edges, and `out` = 1 for the one cycle after the edge that samples the final 1.
- Overlap:
  - Drive the stream 1,1,0,1,1,0,1.
  - Required: `out` pulses after bit 4 and after bit 7 (2 matches). With SEQ_DET_COUNT_EN, `match_count` = 2.
- Mixed stream:
  - After reset, drive 0,1,1,0,1,1,0,1,0,1,1,0,1,0,1,1,0.
  - Required: `out` high exactly after the 5th, 8th and 13th sampled bits.
- No false match:
  - Drive 1,0,1,0,1,1,1,1.
  - Required: `out` stays 0. State ends at S2 (S2 self-loop on 1).
- Reset mid-operation:
  - Drive 1,1,0, assert `reset` for one edge, then drive 1.
  - Required: `out` stays 0 and the state after the final edge is S1.
- Counter saturation (SEQ_DET_COUNT_EN):
  - Drive 300 repetitions of 1,1,0,1.
  - Required: `match_count` = 255 and does not wrap.

Source files
------------

// File: rtl/seq_detect_moore_overlap.sv
// Moore serial pattern detector with full overlap; next state derived from PATTERN via the KMP failure rule.
// Optional match counter enabled by defining SEQ_DET_COUNT_EN.
module seq_detect_moore_overlap #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1101
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic       out
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [7:0] match_count
`endif
);

  localparam int unsigned SW = $clog2(PATTERN_LEN + 1);

  typedef enum logic [SW-1:0] {
    S0      = SW'(0),
    S_MATCH = SW'(PATTERN_LEN)
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_out;

  // Bit of PATTERN at stream position pos (0 = first bit received = MSB).
  function automatic logic f_pat_bit(input int pos);
    logic [PATTERN_LEN-1:0] sh;
    sh = PATTERN << pos;
    return sh[PATTERN_LEN-1];
  endfunction

  // Longest prefix of PATTERN that is a suffix of (prefix k of PATTERN, then b).
  function automatic state_t f_next(input int k, input logic b);
    int   best;
    int   pos;
    logic ok;
    logic sbit;
    best = 0;
    for (int j = 1; j <= PATTERN_LEN; j++) begin
      ok = (j <= k + 1);
      if (ok) begin
        for (int t = 0; t < PATTERN_LEN; t++) begin
          if (t < j) begin
            pos  = k + 1 - j + t;
            sbit = (pos < k) ? f_pat_bit(pos) : b;
            if (sbit != f_pat_bit(t)) ok = 1'b0;
          end
        end
      end
      if (ok) best = j;
    end
    return state_t'(SW'(best));
  endfunction

  // Next-state logic; unreachable encodings fall back to S0.
  always_comb begin
    w_next = S0;
    if (int'(r_state) <= PATTERN_LEN) begin
      w_next = f_next(int'(r_state), in);
    end
  end

  // State register; out is registered alongside it so it equals (state == S_MATCH).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_out   <= (w_next == S_MATCH);
    end
  end

  assign out = r_out;

`ifdef SEQ_DET_COUNT_EN
  logic [7:0] r_count;

  // Saturating match counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 8'd0;
    end else if ((w_next == S_MATCH) && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign match_count = r_count;
`endif

endmodule

// File: tb/tb_seq_detect_moore_overlap.sv
// Directed self-checking bench for seq_detect_moore_overlap (default pattern 1101).
// Counter checks run only when SEQ_DET_COUNT_EN is defined.
module tb_seq_detect_moore_overlap;

  logic clk;
  logic reset;
  logic in;
  logic out;
`ifdef SEQ_DET_COUNT_EN
  logic [7:0] match_count;
`endif

  int n_vec;
  int n_err;

  seq_detect_moore_overlap dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .out        (out)
`ifdef SEQ_DET_COUNT_EN
    ,
    .match_count(match_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input logic exp, input string tag);
    n_vec++;
    assert (out === exp) else begin
      n_err++;
      $error("FAIL %s: out=%b expected %b", tag, out, exp);
    end
  endtask

  // Drive one bit, let one rising edge sample it, then check out.
  task automatic step(input logic b, input logic exp, input string tag);
    in = b;
    @(posedge clk);
    #1;
    check_out(exp, tag);
  endtask

  // One reset edge; in is held at b to show reset has priority.
  task automatic do_reset(input logic b, input string tag);
    reset = 1'b1;
    in    = b;
    @(posedge clk);
    #1;
    check_out(1'b0, tag);
    reset = 1'b0;
  endtask

`ifdef SEQ_DET_COUNT_EN
  task automatic check_cnt(input logic [7:0] exp, input string tag);
    n_vec++;
    assert (match_count === exp) else begin
      n_err++;
      $error("FAIL %s: match_count=%0d expected %0d", tag, match_count, exp);
    end
  endtask
`endif

  logic [0:0] exp_mixed [17];
  logic [0:0] bits_mixed[17];
  logic [16:0] mixed_in;
  logic [16:0] mixed_exp;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    in    = 1'b0;
    #2;

    // Reset then a single match on 0,1,1,0,1.
    do_reset(1'b0, "reset_init");
`ifdef SEQ_DET_COUNT_EN
    check_cnt(8'd0, "cnt_reset");
`endif
    step(1'b0, 1'b0, "single_b1");
    step(1'b1, 1'b0, "single_b2");
    step(1'b1, 1'b0, "single_b3");
    step(1'b0, 1'b0, "single_b4");
    step(1'b1, 1'b1, "single_b5");

    // Reset while out is high, with in=1 during reset.
    do_reset(1'b1, "reset_from_match");

    // Overlap: 1,1,0,1,1,0,1 -> matches after bits 4 and 7.
    step(1'b1, 1'b0, "ovl_b1");
    step(1'b1, 1'b0, "ovl_b2");
    step(1'b0, 1'b0, "ovl_b3");
    step(1'b1, 1'b1, "ovl_b4");
    step(1'b1, 1'b0, "ovl_b5");
    step(1'b0, 1'b0, "ovl_b6");
    step(1'b1, 1'b1, "ovl_b7");
`ifdef SEQ_DET_COUNT_EN
    check_cnt(8'd2, "cnt_overlap");
`endif

    // Mixed stream: matches after sampled bits 5, 8 and 13.
    do_reset(1'b0, "reset_mixed");
    mixed_in  = 17'b0110_1101_0110_1011_0;
    mixed_exp = 17'b0000_1001_0000_1000_0;
    for (int i = 0; i < 17; i++) begin
      step(mixed_in[16-i], mixed_exp[16-i], $sformatf("mixed_b%0d", i + 1));
    end
`ifdef SEQ_DET_COUNT_EN
    check_cnt(8'd3, "cnt_mixed");
`endif

    // No false match: 1,0,1,0,1,1,1,1 ends in S2, so 0,1 completes a match.
    do_reset(1'b0, "reset_nofalse");
    step(1'b1, 1'b0, "nf_b1");
    step(1'b0, 1'b0, "nf_b2");
    step(1'b1, 1'b0, "nf_b3");
    step(1'b0, 1'b0, "nf_b4");
    step(1'b1, 1'b0, "nf_b5");
    step(1'b1, 1'b0, "nf_b6");
    step(1'b1, 1'b0, "nf_b7");
    step(1'b1, 1'b0, "nf_b8");
    step(1'b0, 1'b0, "nf_s2_to_s3");
    step(1'b1, 1'b1, "nf_s3_to_s4");

    // Reset mid-sequence after 1,1,0; then 1 leaves S1, so 1,0,1 completes a match.
    do_reset(1'b0, "reset_pre_mid");
    step(1'b1, 1'b0, "mid_b1");
    step(1'b1, 1'b0, "mid_b2");
    step(1'b0, 1'b0, "mid_b3");
    do_reset(1'b1, "reset_mid");
    step(1'b1, 1'b0, "mid_after_reset");
    step(1'b1, 1'b0, "mid_s1_to_s2");
    step(1'b0, 1'b0, "mid_s2_to_s3");
    step(1'b1, 1'b1, "mid_s3_to_s4");

`ifdef SEQ_DET_COUNT_EN
    // Saturation: 300 repetitions of 1101, one match each.
    do_reset(1'b0, "reset_sat");
    check_cnt(8'd0, "cnt_sat_start");
    for (int r = 1; r <= 300; r++) begin
      in = 1'b1; @(posedge clk); #1;
      in = 1'b1; @(posedge clk); #1;
      in = 1'b0; @(posedge clk); #1;
      in = 1'b1; @(posedge clk); #1;
      if (r == 1 || r == 254 || r == 255 || r == 256 || r == 300) begin
        check_out(1'b1, $sformatf("sat_out_r%0d", r));
        check_cnt((r > 255) ? 8'd255 : 8'(r), $sformatf("sat_cnt_r%0d", r));
      end
    end
    do_reset(1'b0, "reset_after_sat");
    check_cnt(8'd0, "cnt_cleared");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
